// File: rtl/gst_snd_dma.sv
// STE DMA sound frame controller: CPU frame registers plus the fetch FSM feeding the shifter FIFO.
// Optional macro SNDDMA_LATCH_EN keeps a working copy of the frame end, reloaded per frame.
module gst_snd_dma #(
  parameter int unsigned ADDR_W   = 22,
  parameter int unsigned LOAD_LEN = 4
) (
  input  logic              clk32,
  input  logic              resb,
  input  logic              ste,
  input  logic              CS,
  input  logic [5:0]        A,
  input  logic [15:0]       DIN,
  input  logic              RW,
  output logic [15:0]       DOUT,
  input  logic              SREQ,
  input  logic              SLOT,
  output logic [ADDR_W-1:0] SADDR,
  output logic              SLOAD_N,
  output logic              SINT,
  output logic              SACT
);

  localparam int unsigned LcW = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StLoad} state_e;

  state_e             state_q, state_d;
  logic               en_q, loop_q;
  logic [ADDR_W-1:0]  start_q, end_q, cnt_q, saddr_q, end_work;
  logic [LcW-1:0]     lcnt_q;
  logic               sload_n_q, sint_q;
  logic               wr, wr_ctrl, start_play, reload;
  logic               fetch, load_done, frame_end;
  logic [23:0]        start24, end24, cnt24;
  logic               unused_din;

  assign unused_din = ^DIN[15:8];

  // Byte-lane update of a frame address: A=1/4/7 -> [21:16], 2/5/8 -> [15:8], 3/6/9 -> [7:1].
  function automatic logic [ADDR_W-1:0] wr_field(input logic [ADDR_W-1:0] cur,
                                                 input logic [1:0] sel, input logic [7:0] d);
    logic [23:0] v;
    v = 24'(cur);
    case (sel)
      2'd0:    v[23:16] = d;
      2'd1:    v[15:8]  = d;
      default: v[7:0]   = {d[7:1], 1'b0};
    endcase
    return v[ADDR_W-1:0];
  endfunction

  assign wr         = CS & ~RW & ste;
  assign wr_ctrl    = wr && (A == 6'd0);
  assign start_play = wr_ctrl & DIN[0] & ~en_q;
  assign reload     = frame_end & loop_q;

`ifdef SNDDMA_LATCH_EN
  logic [ADDR_W-1:0] end_work_q;
  assign end_work = end_work_q;

  // Reload sees the pre-write end value because end_q only updates on this same edge.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      end_work_q <= '0;
    end else if (start_play || reload) begin
      end_work_q <= end_q;
    end
  end
`else
  assign end_work = end_q;
`endif

  always_comb begin
    state_d   = state_q;
    fetch     = 1'b0;
    load_done = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      StIdle: if (en_q && ste) state_d = StWait;
      StWait: begin
        if (!en_q) begin
          state_d = StIdle;
        end else if (cnt_q == end_work) begin
          frame_end = 1'b1;
          if (!loop_q) state_d = StIdle;
        end else if (SLOT && SREQ && ste) begin
          fetch   = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (lcnt_q == LcW'(LOAD_LEN - 1)) begin
          load_done = 1'b1;
          state_d   = en_q ? StWait : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      loop_q    <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      saddr_q   <= '0;
      lcnt_q    <= '0;
      sload_n_q <= 1'b1;
      sint_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sint_q  <= frame_end;
      if (wr) begin
        case (A)
          6'd1:    start_q <= wr_field(start_q, 2'd0, DIN[7:0]);
          6'd2:    start_q <= wr_field(start_q, 2'd1, DIN[7:0]);
          6'd3:    start_q <= wr_field(start_q, 2'd2, DIN[7:0]);
          6'd7:    end_q   <= wr_field(end_q, 2'd0, DIN[7:0]);
          6'd8:    end_q   <= wr_field(end_q, 2'd1, DIN[7:0]);
          6'd9:    end_q   <= wr_field(end_q, 2'd2, DIN[7:0]);
          default: ;
        endcase
      end
      if (wr_ctrl) begin
        en_q   <= DIN[0];
        loop_q <= DIN[1];
      end
      if (frame_end && !loop_q) en_q <= 1'b0;
      if (start_play || reload) begin
        cnt_q <= start_q;
      end else if (load_done) begin
        cnt_q <= cnt_q + ADDR_W'(2);
      end
      if (fetch) begin
        saddr_q   <= cnt_q;
        sload_n_q <= 1'b0;
        lcnt_q    <= '0;
      end else if (state_q == StLoad) begin
        if (load_done) sload_n_q <= 1'b1;
        else           lcnt_q    <= lcnt_q + LcW'(1);
      end
    end
  end

  assign start24 = 24'(start_q);
  assign end24   = 24'(end_q);
  assign cnt24   = 24'(cnt_q);

  always_comb begin
    DOUT = 16'h0000;
    if (CS && RW && ste) begin
      case (A)
        6'd0:    DOUT = {14'h0, loop_q, en_q};
        6'd1:    DOUT = {8'h00, start24[23:16]};
        6'd2:    DOUT = {8'h00, start24[15:8]};
        6'd3:    DOUT = {8'h00, start24[7:1], 1'b0};
        6'd4:    DOUT = {8'h00, cnt24[23:16]};
        6'd5:    DOUT = {8'h00, cnt24[15:8]};
        6'd6:    DOUT = {8'h00, cnt24[7:1], 1'b0};
        6'd7:    DOUT = {8'h00, end24[23:16]};
        6'd8:    DOUT = {8'h00, end24[15:8]};
        6'd9:    DOUT = {8'h00, end24[7:1], 1'b0};
        default: DOUT = 16'h0000;
      endcase
    end
  end

  assign SADDR   = saddr_q;
  assign SLOAD_N = sload_n_q;
  assign SINT    = sint_q;
  assign SACT    = en_q;

endmodule

// File: tb/tb_gst_snd_dma.sv
// Directed bench for gst_snd_dma: register readback, single/loop frames, stall, end rewrite,
// disable during a load and asynchronous reset.
module tb_gst_snd_dma;
  localparam int unsigned AW = 22;

  logic          clk32 = 1'b0;
  logic          resb  = 1'b0;
  logic          ste   = 1'b1;
  logic          CS    = 1'b0;
  logic          RW    = 1'b1;
  logic [5:0]    A     = 6'd0;
  logic [15:0]   DIN   = 16'h0;
  logic          SREQ  = 1'b0;
  logic          SLOT  = 1'b0;
  logic [15:0]   DOUT;
  logic [AW-1:0] SADDR;
  logic          SLOAD_N, SINT, SACT;

  gst_snd_dma #(.ADDR_W(AW), .LOAD_LEN(4)) dut (
    .clk32(clk32), .resb(resb), .ste(ste), .CS(CS), .A(A), .DIN(DIN), .RW(RW), .DOUT(DOUT),
    .SREQ(SREQ), .SLOT(SLOT), .SADDR(SADDR), .SLOAD_N(SLOAD_N), .SINT(SINT), .SACT(SACT)
  );

  always #5 clk32 = ~clk32;

  int checks = 0;
  int fails  = 0;

  // Observed load pulses: start address and low width in cycles, plus SINT pulse count.
  logic          prev_n = 1'b1;
  int            width  = 0;
  int            widths[$];
  logic [AW-1:0] addrs[$];
  int            sint_cnt = 0;

  always @(negedge clk32) begin
    if (SINT) sint_cnt++;
    if (!SLOAD_N && prev_n) begin
      addrs.push_back(SADDR);
      width = 1;
    end else if (!SLOAD_N) begin
      width++;
    end else if (!prev_n) begin
      widths.push_back(width);
    end
    prev_n = SLOAD_N;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b0; A = a; DIN = {8'h00, d};
    @(negedge clk32);
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic cpu_rd(input logic [5:0] a, output logic [15:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b1; A = a;
    #1 d = DOUT;
    CS = 1'b0;
  endtask

  task automatic slots(input int n);
    repeat (n) begin
      @(negedge clk32);
      SLOT = 1'b1;
      @(negedge clk32);
      SLOT = 1'b0;
      repeat (14) @(negedge clk32);
    end
  endtask

  task automatic chk_addrs(input string tag, input int base, input int n,
                           input logic [AW-1:0] exp[12]);
    chk({tag, "_count"}, 32'(addrs.size() - base), 32'(n));
    if (addrs.size() - base == n)
      for (int i = 0; i < n; i++) chk({tag, "_saddr"}, 32'(addrs[base+i]), 32'(exp[i]));
  endtask

  task automatic wait_load(input string tag);
    int t = 0;
    while (SLOAD_N && t < 8) begin
      @(negedge clk32);
      t++;
    end
    chk(tag, 32'(SLOAD_N), 32'd0);
  endtask

  initial begin
    logic [15:0]   rd;
    logic [AW-1:0] exp[12];
    int            n0, s0, n1;

    // 1: reset state and register readback
    repeat (3) @(negedge clk32);
    resb = 1'b1;
    chk("rst_sload_n", 32'(SLOAD_N), 32'd1);
    chk("rst_saddr", 32'(SADDR), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cpu_rd(6'(i), rd);
      chk($sformatf("rst_reg%0d", i), 32'(rd), 32'd0);
    end
    cpu_wr(6'd1, 8'h01); cpu_wr(6'd2, 8'h00); cpu_wr(6'd3, 8'h00);
    cpu_wr(6'd7, 8'h01); cpu_wr(6'd8, 8'h00); cpu_wr(6'd9, 8'h09);
    cpu_rd(6'd1, rd); chk("start_hi", 32'(rd), 32'h01);
    cpu_rd(6'd3, rd); chk("start_lo", 32'(rd), 32'h00);
    cpu_rd(6'd7, rd); chk("end_hi", 32'(rd), 32'h01);
    cpu_rd(6'd9, rd); chk("end_lo_bit0", 32'(rd), 32'h08);
    cpu_wr(6'd4, 8'h3f);
    cpu_rd(6'd4, rd); chk("cnt_ro", 32'(rd), 32'h00);

    // 2: single frame
    n0 = addrs.size(); s0 = sint_cnt;
    SREQ = 1'b1;
    cpu_wr(6'd0, 8'h01);
    slots(5);
    for (int i = 0; i < 4; i++) exp[i] = AW'(22'h010000 + 2 * i);
    chk_addrs("single", n0, 4, exp);
    for (int i = 0; i < widths.size(); i++) chk("single_width", 32'(widths[i]), 32'd4);
    chk("single_sint", 32'(sint_cnt - s0), 32'd1);
    chk("single_sact", 32'(SACT), 32'd0);
    cpu_rd(6'd0, rd); chk("single_ctrl", 32'(rd), 32'h00);

    // 3: loop mode, three frames
    n0 = addrs.size(); s0 = sint_cnt;
    cpu_wr(6'd0, 8'h03);
    slots(12);
    for (int i = 0; i < 12; i++) exp[i] = AW'(22'h010000 + 2 * (i % 4));
    chk_addrs("loop", n0, 12, exp);
    chk("loop_sint", 32'(sint_cnt - s0), 32'd3);
    chk("loop_sact", 32'(SACT), 32'd1);

    // 4: FIFO backpressure mid-frame
    n0 = addrs.size(); s0 = sint_cnt;
    slots(2);
    SREQ = 1'b0;
    n1 = addrs.size();
    slots(5);
    chk("stall_nofetch", 32'(addrs.size() - n1), 32'd0);
    cpu_rd(6'd4, rd); chk("stall_cnt_hi", 32'(rd), 32'h01);
    cpu_rd(6'd6, rd); chk("stall_cnt_lo", 32'(rd), 32'h04);
    SREQ = 1'b1;
    slots(2);
    for (int i = 0; i < 4; i++) exp[i] = AW'(22'h010000 + 2 * i);
    chk_addrs("stall", n0, 4, exp);
    chk("stall_sint", 32'(sint_cnt - s0), 32'd1);

    // 5: end rewritten after the second fetch of a looping frame
    n0 = addrs.size(); s0 = sint_cnt;
    slots(2);
    cpu_wr(6'd9, 8'h04);
    repeat (4) @(negedge clk32);
`ifdef SNDDMA_LATCH_EN
    chk("endwr_early_sint", 32'(sint_cnt - s0), 32'd0);
    slots(4);
    exp[0] = 22'h010000; exp[1] = 22'h010002; exp[2] = 22'h010004;
    exp[3] = 22'h010006; exp[4] = 22'h010000; exp[5] = 22'h010002;
    chk_addrs("endwr", n0, 6, exp);
    chk("endwr_sint", 32'(sint_cnt - s0), 32'd2);
`else
    chk("endwr_early_sint", 32'(sint_cnt - s0), 32'd1);
    slots(4);
    for (int i = 0; i < 6; i++) exp[i] = AW'(22'h010000 + 2 * (i % 2));
    chk_addrs("endwr", n0, 6, exp);
    chk("endwr_sint", 32'(sint_cnt - s0), 32'd3);
`endif

    // 6a: disable during LOAD completes the pulse, then idles without SINT
    cpu_wr(6'd9, 8'h08);
    n0 = addrs.size(); s0 = sint_cnt;
    @(negedge clk32); SLOT = 1'b1;
    @(negedge clk32); SLOT = 1'b0;
    wait_load("dis_fetch");
    cpu_wr(6'd0, 8'h00);
    repeat (10) @(negedge clk32);
    chk("dis_pulses", 32'(addrs.size() - n0), 32'd1);
    if (widths.size() > 0) chk("dis_width", 32'(widths[widths.size()-1]), 32'd4);
    chk("dis_sint", 32'(sint_cnt - s0), 32'd0);
    chk("dis_sact", 32'(SACT), 32'd0);
    slots(1);
    chk("dis_idle", 32'(addrs.size() - n0), 32'd1);

    // 6b: asynchronous reset mid-LOAD
    cpu_wr(6'd0, 8'h03);
    @(negedge clk32); SLOT = 1'b1;
    @(negedge clk32); SLOT = 1'b0;
    wait_load("rst_fetch");
    #2 resb = 1'b0;
    #1;
    chk("arst_sload_n", 32'(SLOAD_N), 32'd1);
    chk("arst_sact", 32'(SACT), 32'd0);
    chk("arst_saddr", 32'(SADDR), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cpu_rd(6'(i), rd);
      chk($sformatf("arst_reg%0d", i), 32'(rd), 32'd0);
    end
    @(negedge clk32); resb = 1'b1;

    // ste=0 makes the block inert
    ste = 1'b0;
    cpu_wr(6'd1, 8'h3f);
    ste = 1'b1;
    cpu_rd(6'd1, rd); chk("ste_nowrite", 32'(rd), 32'h00);
    cpu_wr(6'd1, 8'h2a);
    ste = 1'b0;
    cpu_rd(6'd1, rd); chk("ste_read0", 32'(rd), 32'h00);
    ste = 1'b1;
    cpu_rd(6'd1, rd); chk("ste_readback", 32'(rd), 32'h2a);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
